// File: rtl/replica_timing_monitor_if.sv
// Signal bundle between the replica timing monitor and its surroundings.
// The master drives the control and replica-return inputs; the slave (the monitor)
// drives the launch level, the margin code and the status outputs.
interface replica_timing_monitor_if #(
    parameter int PERIOD_W = 8,
    parameter int CODE_W   = 4
);
    logic                enable_i;
    logic                clear_i;
    logic [PERIOD_W-1:0] period_i;
    logic                replica_launch_o;
    logic                replica_capture_i;
    logic [CODE_W-1:0]   margin_code_o;
    logic                slow_req_o;
    logic                window_done_o;
    logic [7:0]          err_count_o;

    modport master (
        output enable_i, clear_i, period_i, replica_capture_i,
        input  replica_launch_o, margin_code_o, slow_req_o, window_done_o, err_count_o
    );

    modport slave (
        input  enable_i, clear_i, period_i, replica_capture_i,
        output replica_launch_o, margin_code_o, slow_req_o, window_done_o, err_count_o
    );
endinterface

// File: rtl/replica_timing_monitor.sv
// Probe sequencer for the frontend critical-path replica. Launches a transition into
// the replica, checks it arrived one clock later, counts late arrivals per window and
// steers a margin code up or down; requests a slowdown when the code is exhausted.
module replica_timing_monitor #(
    parameter int PERIOD_W   = 8,
    parameter int WINDOW     = 16,
    parameter int ERR_THRESH = 2,
    parameter int CODE_W     = 4,
    parameter int CODE_INIT  = 8,
    parameter int SETTLE     = 4,
    parameter bit INVERT     = 1'b0
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    replica_timing_monitor_if.slave bus
);
    localparam int SAMPLE_W = $clog2(WINDOW + 1);
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_LAUNCH  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;

    localparam logic [SAMPLE_W-1:0] WINDOW_C      = SAMPLE_W'(WINDOW);
    localparam logic [7:0]          THRESH_C      = 8'(ERR_THRESH);
    localparam logic [CODE_W-1:0]   CODE_MAX_C    = '1;
    localparam logic [CODE_W-1:0]   CODE_INIT_C   = CODE_W'(CODE_INIT);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD_C = SETTLE_W'(SETTLE - 1);

    logic [2:0]          state_q, state_d;
    logic [PERIOD_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                slow_q, slow_d;
    logic                launch_q, launch_d;
    logic                window_done_q, window_done_d;

    logic [PERIOD_W-1:0] period_eff;
    logic [PERIOD_W-1:0] wait_load;
    logic [SAMPLE_W-1:0] sample_inc;
    logic                probe_err;

    // Next-state logic: probe sequencing, window evaluation, clear override.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        err_cnt_d     = err_cnt_q;
        code_d        = code_q;
        slow_d        = slow_q;
        launch_d      = launch_q;
        window_done_d = 1'b0;

        // A zero period still waits one cycle; the counter holds cycles remaining minus one.
        period_eff = (bus.period_i == '0) ? PERIOD_W'(1) : bus.period_i;
        wait_load  = period_eff - PERIOD_W'(1);
        sample_inc = sample_cnt_q + SAMPLE_W'(1);
        // launch_q already holds the new level during CAPTURE.
        probe_err  = bus.replica_capture_i != (launch_q ^ INVERT);

        case (state_q)
            S_IDLE: begin
                if (bus.enable_i) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_load;
                end
            end
            S_WAIT: begin
                if (!bus.enable_i) begin
                    state_d      = S_IDLE;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                end else if (wait_cnt_q == '0) begin
                    state_d = S_LAUNCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - PERIOD_W'(1);
                end
            end
            S_LAUNCH: begin
                // A launch in flight always completes its capture, even if enable drops.
                launch_d = ~launch_q;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (probe_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                sample_cnt_d = sample_inc;
                if (!bus.enable_i) begin
                    // Partial window is thrown away.
                    state_d      = S_IDLE;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                end else if (sample_inc == WINDOW_C) begin
                    state_d = S_EVAL;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_load;
                end
            end
            S_EVAL: begin
                window_done_d = 1'b1;
                if (err_cnt_q >= THRESH_C) begin
                    if (code_q == CODE_MAX_C) slow_d = 1'b1;
                    else                      code_d = code_q + CODE_W'(1);
                end else if (err_cnt_q == 8'd0) begin
                    slow_d = 1'b0;
                    if (code_q != '0) code_d = code_q - CODE_W'(1);
                end
                sample_cnt_d = '0;
                err_cnt_d    = '0;
                if (!bus.enable_i) begin
                    state_d = S_IDLE;
                end else if (code_d != code_q) begin
                    // Give the tuning logic time to act on the new code before probing.
                    state_d      = S_SETTLE;
                    settle_cnt_d = SETTLE_LOAD_C;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_load;
                end
            end
            S_SETTLE: begin
                if (!bus.enable_i) begin
                    state_d = S_IDLE;
                end else if (settle_cnt_q == '0) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_load;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides everything except the launch level, which the replica still holds.
        if (bus.clear_i) begin
            state_d       = S_IDLE;
            wait_cnt_d    = '0;
            settle_cnt_d  = '0;
            sample_cnt_d  = '0;
            err_cnt_d     = '0;
            code_d        = CODE_INIT_C;
            slow_d        = 1'b0;
            launch_d      = launch_q;
            window_done_d = 1'b0;
        end
    end

    // State registers; window_done rises the cycle after EVAL, together with the new code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
            err_cnt_q     <= '0;
            code_q        <= CODE_INIT_C;
            slow_q        <= 1'b0;
            launch_q      <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            err_cnt_q     <= err_cnt_d;
            code_q        <= code_d;
            slow_q        <= slow_d;
            launch_q      <= launch_d;
            window_done_q <= window_done_d;
        end
    end

    assign bus.replica_launch_o = launch_q;
    assign bus.margin_code_o    = code_q;
    assign bus.slow_req_o       = slow_q;
    assign bus.window_done_o    = window_done_q;
    assign bus.err_count_o      = err_cnt_q;
endmodule
